// File: rtl/sandbox_channel_router.sv
// Multi-channel sandbox router: decodes the channel ID of each host frame, dispatches the payload
// to one or all DUT channels, and returns round-robin arbitrated responses and error frames.
module sandbox_channel_router #(
  parameter  int CHANNELS      = 4,
  parameter  int PAYLOAD_WIDTH = 40,
  parameter  int TIMEOUT       = 1024,
  localparam int FRAME_WIDTH   = PAYLOAD_WIDTH + 8
) (
  input  logic                              masterClock,
  input  logic                              reset,
  input  logic [FRAME_WIDTH-1:0]            inputData,
  input  logic                              dataReceived,
  output logic                              clearDR,
  output logic [FRAME_WIDTH-1:0]            outputData,
  output logic                              transmit,
  input  logic                              transmitting,
  output logic [PAYLOAD_WIDTH-1:0]          cmdData,
  output logic [CHANNELS-1:0]               cmdValid,
  input  logic [CHANNELS-1:0]               cmdReady,
  input  logic [CHANNELS*PAYLOAD_WIDTH-1:0] respData,
  input  logic [CHANNELS-1:0]               respValid,
  output logic [CHANNELS-1:0]               respReady
);

  localparam int PTR_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_WIDTH = $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [7:0] BROADCAST_ID = 8'hFE;
  localparam logic [7:0] ERROR_ID     = 8'hFF;
  localparam logic [7:0] ERR_BAD_ID   = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT  = 8'h02;

  typedef enum logic [2:0] {IDLE, DISPATCH, CLEAR, TX_START, TX_WAIT_HI, TX_WAIT_LO} stateType;

  stateType                 state, nextState;
  logic [PTR_WIDTH-1:0]     rrPtr;
  logic                     guard;
  logic                     errorFrame;
  logic [CHANNELS-1:0]      pendingMask;
  logic [CHANNELS-1:0]      nextMask;
  logic [CNT_WIDTH-1:0]     timeoutCount;
  logic [7:0]               activeId;

  logic [7:0]               rxId;
  logic [PAYLOAD_WIDTH-1:0] rxPayload;
  logic                     idBroadcast;
  logic                     idValid;
  logic [CHANNELS-1:0]      targetMask;

  logic                     anyResp;
  int                       grantSel;
  logic [PAYLOAD_WIDTH-1:0] grantData;
  logic [PTR_WIDTH-1:0]     nextPtr;

  function automatic logic [PAYLOAD_WIDTH-1:0] errorPayload(input logic [7:0] code,
                                                            input logic [7:0] id);
    return PAYLOAD_WIDTH'({code, id});
  endfunction

  assign rxId        = inputData[FRAME_WIDTH-1 -: 8];
  assign rxPayload   = inputData[PAYLOAD_WIDTH-1:0];
  assign idBroadcast = (rxId == BROADCAST_ID);
  assign idValid     = (int'(rxId) < CHANNELS) || idBroadcast;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (latch).
  always_comb begin
    targetMask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      targetMask[i] = idBroadcast || (int'(rxId) == i);
    end
  end

  // Scan from rrPtr upward with wrap; the first requester found wins.
  always_comb begin : grantLogic
    int idx;
    idx       = 0;
    grantSel  = 0;
    grantData = '0;
    anyResp   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!anyResp && respValid[idx]) begin
        anyResp   = 1'b1;
        grantSel  = idx;
        grantData = respData[idx*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  assign nextPtr  = (grantSel >= CHANNELS - 1) ? '0 : PTR_WIDTH'(grantSel + 1);
  assign nextMask = pendingMask & ~(cmdValid & cmdReady);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge masterClock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (anyResp)                       nextState = TX_START;
        else if (dataReceived && !guard)   nextState = idValid ? DISPATCH : TX_START;
      end
      DISPATCH: begin
        if (nextMask == '0)                nextState = CLEAR;
        else if (timeoutCount == LAST_COUNT) nextState = TX_START;
      end
      CLEAR:      nextState = IDLE;
      TX_START:   nextState = TX_WAIT_HI;
      TX_WAIT_HI: if (transmitting)  nextState = TX_WAIT_LO;
      TX_WAIT_LO: if (!transmitting) nextState = IDLE;
      default:    nextState = IDLE;
    endcase
  end

  // Error frames release the received frame from TX_START instead of passing through CLEAR.
  always_comb begin
    clearDR   = 1'b0;
    transmit  = 1'b0;
    cmdValid  = '0;
    respReady = '0;
    case (state)
      IDLE: begin
        for (int i = 0; i < CHANNELS; i++) begin
          respReady[i] = anyResp && (grantSel == i);
        end
      end
      DISPATCH: cmdValid = pendingMask;
      CLEAR:    clearDR  = 1'b1;
      TX_START: begin
        transmit = 1'b1;
        clearDR  = errorFrame;
      end
      default: ;
    endcase
  end

  always_ff @(posedge masterClock) begin
    if (reset) begin
      rrPtr        <= '0;
      guard        <= 1'b0;
      errorFrame   <= 1'b0;
      pendingMask  <= '0;
      timeoutCount <= '0;
      activeId     <= '0;
      outputData   <= '0;
      cmdData      <= '0;
    end else begin
      // The first IDLE cycle after any clearDR ignores dataReceived while the UART drops it.
      if (clearDR)            guard <= 1'b1;
      else if (state == IDLE) guard <= 1'b0;

      case (state)
        IDLE: begin
          if (anyResp) begin
            outputData <= {8'(grantSel), grantData};
            rrPtr      <= nextPtr;
            errorFrame <= 1'b0;
          end else if (dataReceived && !guard) begin
            activeId <= rxId;
            if (idValid) begin
              cmdData      <= rxPayload;
              pendingMask  <= targetMask;
              timeoutCount <= '0;
            end else begin
              outputData <= {ERROR_ID, errorPayload(ERR_BAD_ID, rxId)};
              errorFrame <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          pendingMask  <= nextMask;
          timeoutCount <= timeoutCount + 1'b1;
          if ((nextMask != '0) && (timeoutCount == LAST_COUNT)) begin
            pendingMask <= '0;
            outputData  <= {ERROR_ID, errorPayload(ERR_TIMEOUT, activeId)};
            errorFrame  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sandbox_channel_router.sv
// Directed bench for sandbox_channel_router: unicast, guard, broadcast, bad ID, round robin,
// response priority, dispatch timeout and mid-operation reset.
module tb_sandbox_channel_router;

  localparam int CH = 4;
  localparam int PW = 40;
  localparam int FW = PW + 8;
  localparam int TO = 16;

  logic             masterClock = 1'b0;
  logic             reset;
  logic [FW-1:0]    inputData;
  logic             dataReceived;
  logic             clearDR;
  logic [FW-1:0]    outputData;
  logic             transmit;
  logic             transmitting;
  logic [PW-1:0]    cmdData;
  logic [CH-1:0]    cmdValid;
  logic [CH-1:0]    cmdReady;
  logic [CH*PW-1:0] respData;
  logic [CH-1:0]    respValid;
  logic [CH-1:0]    respReady;

  int checkCount = 0;
  int passCount  = 0;

  sandbox_channel_router #(.CHANNELS(CH), .PAYLOAD_WIDTH(PW), .TIMEOUT(TO)) dut (
    .masterClock (masterClock),
    .reset       (reset),
    .inputData   (inputData),
    .dataReceived(dataReceived),
    .clearDR     (clearDR),
    .outputData  (outputData),
    .transmit    (transmit),
    .transmitting(transmitting),
    .cmdData     (cmdData),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .respData    (respData),
    .respValid   (respValid),
    .respReady   (respReady)
  );

  always #5 masterClock = ~masterClock;

  function automatic logic [PW-1:0] respWord(input int i);
    return 40'hC0FFEE0000 + PW'(i);
  endfunction

  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checkCount++; if (clearDR !== 1'b0) $display("FAIL reset_clearDR: got %b want 0", clearDR); else passCount++;
    checkCount++; if (transmit !== 1'b0) $display("FAIL reset_transmit: got %b want 0", transmit); else passCount++;
    checkCount++; if (cmdValid !== 4'b0000) $display("FAIL reset_cmdValid: got %b want 0000", cmdValid); else passCount++;
    checkCount++; if (respReady !== 4'b0000) $display("FAIL reset_respReady: got %b want 0000", respReady); else passCount++;
    checkCount++; if (outputData !== 48'h0) $display("FAIL reset_outputData: got %h want 0", outputData); else passCount++;
    checkCount++; if (cmdData !== 40'h0) $display("FAIL reset_cmdData: got %h want 0", cmdData); else passCount++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unicast();
    logic [CH-1:0] cv[6];
    logic          clr[6];
    int            clrCount;
    int            txCount;
    clrCount = 0;
    txCount  = 0;
    inputData    = 48'h02_0000ABCDEF;
    dataReceived = 1'b1;
    cmdReady     = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      cv[i]  = cmdValid;
      clr[i] = clearDR;
      if (clearDR) clrCount++;
      if (transmit) txCount++;
      if (clearDR) dataReceived = 1'b0;
    end
    cmdReady = '0;
    checkCount++; if (cv[0] !== 4'b0100) $display("FAIL unicast_cmdValid_n1: got %b want 0100", cv[0]); else passCount++;
    checkCount++; if (cv[1] !== 4'b0000) $display("FAIL unicast_cmdValid_n2: got %b want 0000", cv[1]); else passCount++;
    checkCount++; if (clr[1] !== 1'b1) $display("FAIL unicast_clearDR_n2: got %b want 1", clr[1]); else passCount++;
    checkCount++; if (cmdData !== 40'h0000ABCDEF) $display("FAIL unicast_cmdData: got %h want 0000abcdef", cmdData); else passCount++;
    checkCount++; if (clrCount != 1) $display("FAIL unicast_clearDR_count: got %0d want 1", clrCount); else passCount++;
    checkCount++; if (txCount != 0) $display("FAIL unicast_transmit_count: got %0d want 0", txCount); else passCount++;
  endtask

  task automatic test_guard();
    inputData    = {8'h00, 40'h1111111111};
    dataReceived = 1'b1;
    cmdReady     = 4'b0001;
    tick();
    checkCount++; if (cmdValid !== 4'b0001) $display("FAIL guard_first_cmdValid: got %b want 0001", cmdValid); else passCount++;
    tick();
    checkCount++; if (clearDR !== 1'b1) $display("FAIL guard_first_clearDR: got %b want 1", clearDR); else passCount++;
    // A new frame is already waiting when the old one is released.
    inputData = {8'h03, 40'h3333333333};
    cmdReady  = 4'b1000;
    tick();
    tick();
    checkCount++; if (cmdValid !== 4'b0000) $display("FAIL guard_ignored: got %b want 0000", cmdValid); else passCount++;
    tick();
    checkCount++; if (cmdValid !== 4'b1000) $display("FAIL guard_second_cmdValid: got %b want 1000", cmdValid); else passCount++;
    checkCount++; if (cmdData !== 40'h3333333333) $display("FAIL guard_second_cmdData: got %h want 3333333333", cmdData); else passCount++;
    tick();
    checkCount++; if (clearDR !== 1'b1) $display("FAIL guard_second_clearDR: got %b want 1", clearDR); else passCount++;
    dataReceived = 1'b0;
    cmdReady     = '0;
    idle(2);
  endtask

  task automatic test_broadcast();
    logic [CH-1:0] rdy[5]   = '{4'b1000, 4'b0001, 4'b0100, 4'b0010, 4'b0000};
    logic [CH-1:0] expCv[5] = '{4'b1111, 4'b0111, 4'b0110, 4'b0010, 4'b0000};
    logic          expClr[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int            clrCount;
    int            txCount;
    clrCount = 0;
    txCount  = 0;
    inputData    = {8'hFE, 40'h1122334455};
    dataReceived = 1'b1;
    cmdReady     = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCount++;
      if (cmdValid !== expCv[i]) $display("FAIL broadcast_cmdValid_%0d: got %b want %b", i, cmdValid, expCv[i]);
      else passCount++;
      checkCount++;
      if (clearDR !== expClr[i]) $display("FAIL broadcast_clearDR_%0d: got %b want %b", i, clearDR, expClr[i]);
      else passCount++;
      if (clearDR) clrCount++;
      if (transmit) txCount++;
      cmdReady = rdy[i];
      if (clearDR) dataReceived = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (clearDR) clrCount++;
      if (transmit) txCount++;
    end
    checkCount++; if (cmdData !== 40'h1122334455) $display("FAIL broadcast_cmdData: got %h want 1122334455", cmdData); else passCount++;
    checkCount++; if (clrCount != 1) $display("FAIL broadcast_clearDR_count: got %0d want 1", clrCount); else passCount++;
    checkCount++; if (txCount != 0) $display("FAIL broadcast_transmit_count: got %0d want 0", txCount); else passCount++;
  endtask

  task automatic test_bad_id();
    int clrCount;
    int txCount;
    clrCount = 0;
    txCount  = 0;
    inputData    = {8'h07, 40'h5555555555};
    dataReceived = 1'b1;
    tick();
    checkCount++; if (transmit !== 1'b1) $display("FAIL badid_transmit: got %b want 1", transmit); else passCount++;
    checkCount++; if (clearDR !== 1'b1) $display("FAIL badid_clearDR: got %b want 1", clearDR); else passCount++;
    checkCount++; if (outputData !== 48'hFF_000000_0107) $display("FAIL badid_outputData: got %h want ff0000000107", outputData); else passCount++;
    dataReceived = 1'b0;
    tick();
    transmitting = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clearDR) clrCount++;
      if (transmit) txCount++;
    end
    transmitting = 1'b0;
    checkCount++; if (txCount != 0) $display("FAIL badid_extra_transmit: got %0d want 0", txCount); else passCount++;
    checkCount++; if (clrCount != 0) $display("FAIL badid_extra_clearDR: got %0d want 0", clrCount); else passCount++;
    // Back in IDLE after the UART finishes; the first IDLE cycle is a guard cycle.
    inputData    = {8'h01, 40'h0101010101};
    dataReceived = 1'b1;
    cmdReady     = 4'b0010;
    tick();
    tick();
    checkCount++; if (cmdValid !== 4'b0000) $display("FAIL badid_guard: got %b want 0000", cmdValid); else passCount++;
    tick();
    checkCount++; if (cmdValid !== 4'b0010) $display("FAIL badid_then_dispatch: got %b want 0010", cmdValid); else passCount++;
    tick();
    dataReceived = 1'b0;
    cmdReady     = '0;
    idle(2);
  endtask

  task automatic test_round_robin();
    int            g;
    logic [FW-1:0] expFrame;
    respValid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      g        = k % CH;
      expFrame = {8'(g), respWord(g)};
      checkCount++;
      if (respReady !== 4'(1 << g)) $display("FAIL rr_respReady_%0d: got %b want %b", k, respReady, 4'(1 << g));
      else passCount++;
      tick();
      checkCount++;
      if (transmit !== 1'b1) $display("FAIL rr_transmit_%0d: got %b want 1", k, transmit);
      else passCount++;
      checkCount++;
      if (outputData !== expFrame) $display("FAIL rr_outputData_%0d: got %h want %h", k, outputData, expFrame);
      else passCount++;
      tick();
      checkCount++;
      if (transmit !== 1'b0) $display("FAIL rr_transmit_single_%0d: got %b want 0", k, transmit);
      else passCount++;
      transmitting = 1'b1;
      tick();
      tick();
      transmitting = 1'b0;
      tick();
      #1;
    end
    respValid = '0;
    idle(2);
  endtask

  task automatic test_priority();
    // rrPtr is 1 here; only channel 2 requests.
    respValid    = 4'b0100;
    inputData    = {8'h00, 40'h0F0F0F0F0F};
    dataReceived = 1'b1;
    cmdReady     = 4'b0001;
    #1;
    checkCount++; if (respReady !== 4'b0100) $display("FAIL prio_respReady: got %b want 0100", respReady); else passCount++;
    tick();
    respValid = '0;
    checkCount++; if (transmit !== 1'b1) $display("FAIL prio_transmit: got %b want 1", transmit); else passCount++;
    checkCount++; if (cmdValid !== 4'b0000) $display("FAIL prio_no_cmd: got %b want 0000", cmdValid); else passCount++;
    checkCount++; if (clearDR !== 1'b0) $display("FAIL prio_no_clearDR: got %b want 0", clearDR); else passCount++;
    checkCount++; if (outputData !== {8'h02, respWord(2)}) $display("FAIL prio_outputData: got %h want %h", outputData, {8'h02, respWord(2)}); else passCount++;
    tick();
    transmitting = 1'b1;
    tick();
    transmitting = 1'b0;
    tick();
    tick();
    checkCount++; if (cmdValid !== 4'b0001) $display("FAIL prio_cmd_after: got %b want 0001", cmdValid); else passCount++;
    tick();
    dataReceived = 1'b0;
    cmdReady     = '0;
    idle(2);
  endtask

  task automatic test_timeout();
    int highCount;
    bit done;
    highCount = 0;
    done      = 1'b0;
    inputData    = {8'h01, 40'hAAAAAAAAAA};
    dataReceived = 1'b1;
    cmdReady     = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (cmdValid[1]) highCount++;
      if (transmit) done = 1'b1;
    end
    checkCount++; if (done !== 1'b1) $display("FAIL timeout_no_abort: got %b want 1 within 40 cycles", done); else passCount++;
    checkCount++; if (highCount != TO) $display("FAIL timeout_cmdValid_cycles: got %0d want %0d", highCount, TO); else passCount++;
    checkCount++; if (clearDR !== 1'b1) $display("FAIL timeout_clearDR: got %b want 1", clearDR); else passCount++;
    checkCount++; if (cmdValid !== 4'b0000) $display("FAIL timeout_cmdValid_dropped: got %b want 0000", cmdValid); else passCount++;
    checkCount++; if (outputData !== 48'hFF_000000_0201) $display("FAIL timeout_outputData: got %h want ff0000000201", outputData); else passCount++;
    dataReceived = 1'b0;
    tick();
    transmitting = 1'b1;
    tick();
    tick();
    transmitting = 1'b0;
    idle(3);
  endtask

  task automatic test_reset_mid();
    // Reset while waiting for the UART to finish.
    respValid = 4'b0001;
    #1;
    tick();
    respValid = '0;
    tick();
    transmitting = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checkCount++; if (transmit !== 1'b0) $display("FAIL rst_tx_transmit: got %b want 0", transmit); else passCount++;
    checkCount++; if (clearDR !== 1'b0) $display("FAIL rst_tx_clearDR: got %b want 0", clearDR); else passCount++;
    checkCount++; if (outputData !== 48'h0) $display("FAIL rst_tx_outputData: got %h want 0", outputData); else passCount++;
    checkCount++; if (respReady !== 4'b0000) $display("FAIL rst_tx_respReady: got %b want 0000", respReady); else passCount++;
    reset        = 1'b0;
    transmitting = 1'b0;
    tick();
    checkCount++; if (transmit !== 1'b0) $display("FAIL rst_tx_no_transmit: got %b want 0", transmit); else passCount++;
    idle(1);
    // Reset while a command is dispatching; the frame is still pending afterwards.
    inputData    = {8'h03, 40'h0123456789};
    dataReceived = 1'b1;
    cmdReady     = '0;
    tick();
    checkCount++; if (cmdValid !== 4'b1000) $display("FAIL rst_disp_before: got %b want 1000", cmdValid); else passCount++;
    tick();
    reset = 1'b1;
    tick();
    checkCount++; if (cmdValid !== 4'b0000) $display("FAIL rst_disp_cmdValid: got %b want 0000", cmdValid); else passCount++;
    checkCount++; if (cmdData !== 40'h0) $display("FAIL rst_disp_cmdData: got %h want 0", cmdData); else passCount++;
    checkCount++; if (clearDR !== 1'b0) $display("FAIL rst_disp_clearDR: got %b want 0", clearDR); else passCount++;
    checkCount++; if (outputData !== 48'h0) $display("FAIL rst_disp_outputData: got %h want 0", outputData); else passCount++;
    reset = 1'b0;
    tick();
    checkCount++; if (cmdValid !== 4'b1000) $display("FAIL rst_redispatch: got %b want 1000", cmdValid); else passCount++;
    checkCount++; if (cmdData !== 40'h0123456789) $display("FAIL rst_redispatch_data: got %h want 0123456789", cmdData); else passCount++;
    cmdReady = 4'b1000;
    tick();
    checkCount++; if (clearDR !== 1'b1) $display("FAIL rst_redispatch_clearDR: got %b want 1", clearDR); else passCount++;
    dataReceived = 1'b0;
    cmdReady     = '0;
    idle(2);
  endtask

  initial begin
    reset        = 1'b1;
    inputData    = '0;
    dataReceived = 1'b0;
    transmitting = 1'b0;
    cmdReady     = '0;
    respValid    = '0;
    for (int i = 0; i < CH; i++) respData[i*PW +: PW] = respWord(i);

    test_reset();
    test_unicast();
    idle(2);
    test_guard();
    test_broadcast();
    idle(2);
    test_bad_id();
    test_round_robin();
    test_priority();
    test_timeout();
    test_reset_mid();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
